dmem_wait_responder: RTL and testbench



---
 rtl/dmem_resp_pkg.sv | 31 +++
 rtl/dmem_word_array.sv | 29 ++
 rtl/dmem_wait_responder.sv | 126 ++++++++++++
 tb/tb_dmem_wait_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for the wait-state data-memory responder.
// Holds the FSM state enum, default base address and the address translator.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] DEFAULT_BASE = 32'h10010000;
  localparam int CNT_W = 4;
  localparam int IDX_W_MAX = 10;

  // Returns {err, raw word index}; the index is not masked to depth so callers
  // can narrow it to their own array size.
  function automatic logic [IDX_W_MAX:0] dmemTranslate(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned depth
  );
    logic [31:0] off;
    logic [31:0] lim;
    logic err;
    off = addr - base;
    lim = depth << 2;
    err = (off[1:0] != 2'b00) || (off >= lim);
    return {err, off[IDX_W_MAX+1:2]};
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// DEPTH_WORDS x 32 storage: synchronous write, synchronous clear, combinational read.
module dmem_word_array #(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/dmem_wait_responder.sv
// Memory-side responder for the CPU data bus: MARS byte address translation,
// configurable wait states, ready handshake and out-of-range/misalignment flags.
module dmem_wait_responder
  import dmem_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE,
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ena,
  input  logic        i_wena,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data_in,
  output logic [31:0] o_data_out,
  output logic        o_ready,
  output logic        o_addr_err,
  output logic        o_busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
  localparam logic [IDX_W_MAX-1:0] IDX_MASK = IDX_W_MAX'(DEPTH_WORDS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wena;
  logic             r_err;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_data;

  logic [IDX_W_MAX:0]   w_xlat;
  logic [IDX_W_MAX-1:0] w_rawIdx;
  logic                 w_reqErr;
  logic [IDX_W-1:0]     w_reqIdx;
  logic                 w_selErr;
  logic                 w_selWena;
  logic [IDX_W-1:0]     w_ridx;
  logic [31:0]          w_rdata;
  logic                 w_enterResp;
  logic                 w_we;

  // Index bits above the array size can only be set when the offset is already
  // out of range, so folding them into the error keeps every bit meaningful.
  assign w_xlat   = dmemTranslate(i_addr, BASE_ADDR, DEPTH_WORDS);
  assign w_rawIdx = w_xlat[IDX_W_MAX-1:0];
  assign w_reqErr = w_xlat[IDX_W_MAX] | (|(w_rawIdx & ~IDX_MASK));
  assign w_reqIdx = w_rawIdx[IDX_W-1:0];

  // With zero wait states the response is formed straight from the request.
  assign w_selErr    = (r_state == IDLE) ? w_reqErr : r_err;
  assign w_selWena   = (r_state == IDLE) ? i_wena   : r_wena;
  assign w_ridx      = (r_state == IDLE) ? w_reqIdx : r_idx;
  assign w_enterResp = ((r_state == IDLE) && i_ena && (WAIT_CYCLES == 0)) ||
                       ((r_state == WAIT) && (r_cnt == CNT_W'(1)));
  assign w_we        = (r_state == RESP) && r_wena && !r_err;

  dmem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (w_we),
    .i_widx (r_idx),
    .i_wdata(r_data),
    .i_ridx (w_ridx),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wena     <= 1'b0;
      r_err      <= 1'b0;
      r_idx      <= '0;
      r_data     <= '0;
      o_data_out <= '0;
      o_ready    <= 1'b0;
      o_addr_err <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_ready    <= 1'b0;
      o_addr_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_ena) begin
            r_wena  <= i_wena;
            r_err   <= w_reqErr;
            r_idx   <= w_reqIdx;
            r_data  <= i_data_in;
            r_cnt   <= WAIT_LD;
            r_state <= (WAIT_CYCLES > 0) ? WAIT : RESP;
            o_busy  <= 1'b1;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
      if (w_enterResp) begin
        o_ready    <= 1'b1;
        o_addr_err <= w_selErr;
        if (w_selErr) begin
          o_data_out <= '0;
        end else if (!w_selWena) begin
          o_data_out <= w_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Scoreboard bench for dmem_wait_responder: a WAIT_CYCLES=2 instance for the
// main scenarios and a WAIT_CYCLES=0 instance for the back-to-back case.
module tb_dmem_wait_responder;

  localparam logic [31:0] BASE = 32'h10010000;
  localparam int WAITS = 2;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ena, wena;
  logic [31:0] addr, dataIn;
  logic [31:0] dataOut;
  logic        ready, addrErr, busy;

  logic        ena0, wena0;
  logic [31:0] addr0, din0;
  logic [31:0] dout0;
  logic        rdy0, err0, busy0;

  int testsRun = 0;
  int testsFailed = 0;

  exp_t sbq[$];
  logic [31:0] modelMem [32];
  logic [31:0] modelDout;

  dmem_wait_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(32), .WAIT_CYCLES(WAITS)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_wena(wena), .i_addr(addr),
    .i_data_in(dataIn), .o_data_out(dataOut), .o_ready(ready),
    .o_addr_err(addrErr), .o_busy(busy)
  );

  dmem_wait_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(32), .WAIT_CYCLES(0)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena0), .i_wena(wena0), .i_addr(addr0),
    .i_data_in(din0), .o_data_out(dout0), .o_ready(rdy0),
    .o_addr_err(err0), .o_busy(busy0)
  );

  function automatic void modelReset();
    for (int i = 0; i < 32; i++) modelMem[i] = '0;
    modelDout = '0;
  endfunction

  // Reference behaviour of one transaction on the 32-word instance.
  function automatic exp_t modelAccess(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    exp_t e;
    off = a - BASE;
    e.err = (off[1:0] != 2'b00) || (off >= 32'd128);
    if (e.err) modelDout = '0;
    else if (we) modelMem[off[6:2]] = d;
    else modelDout = modelMem[off[6:2]];
    e.data = modelDout;
    return e;
  endfunction

  // Drives one request, scrambles the inputs after acceptance and waits (bounded) for ready.
  task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rdata, output logic rerr, output int lat,
                               output logic busyAcc, output logic readyAfter);
    ena = 1'b1; wena = we; addr = a; dataIn = d;
    @(posedge clk); #1;
    busyAcc = busy;
    ena = 1'b0; wena = ~we; addr = a + 32'd4; dataIn = ~d;
    lat = 0;
    while (!ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = dataOut;
    rerr = addrErr;
    @(posedge clk); #1;
    readyAfter = ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; wena = 1'b0; addr = '0; dataIn = '0;
    ena0 = 1'b0; wena0 = 1'b0; addr0 = '0; din0 = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    testsRun++;
    if (dataOut !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_data_out: got %h expected 0", dataOut); end
    testsRun++;
    if ({ready, addrErr, busy} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_flags: got %b expected 000", {ready, addrErr, busy}); end
    testsRun++;
    if ({dout0, rdy0, err0, busy0} !== 35'h0) begin testsFailed++; $display("[TB] FAIL reset_dut0: got %h expected 0", {dout0, rdy0, err0, busy0}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_basic();
    exp_t e;
    logic [31:0] rd;
    logic re, bAcc, rAfter;
    int lat;
    sbq.push_back(modelAccess(1'b0, BASE, 32'h0));
    applyStimulus(1'b0, BASE, 32'h0, rd, re, lat, bAcc, rAfter);
    e = sbq.pop_front();
    testsRun++;
    if (lat !== WAITS) begin testsFailed++; $display("[TB] FAIL read_latency: got %0d expected %0d", lat, WAITS); end
    testsRun++;
    if ({rd, re} !== {e.data, e.err}) begin testsFailed++; $display("[TB] FAIL read_base: got %h/%b expected %h/%b", rd, re, e.data, e.err); end
    testsRun++;
    if (bAcc !== 1'b1) begin testsFailed++; $display("[TB] FAIL busy_after_accept: got %b expected 1", bAcc); end
    testsRun++;
    if (rAfter !== 1'b0) begin testsFailed++; $display("[TB] FAIL ready_one_cycle: got %b expected 0", rAfter); end
  endtask

  task automatic test_write_read();
    txn_t tbl[3] = '{'{1'b1, BASE + 32'h4, 32'hDEADBEEF},
                     '{1'b0, BASE + 32'h4, 32'h0},
                     '{1'b0, BASE + 32'h8, 32'h0}};
    exp_t e;
    logic [31:0] rd;
    logic re, bAcc, rAfter;
    int lat;
    foreach (tbl[i]) begin
      sbq.push_back(modelAccess(tbl[i].we, tbl[i].addr, tbl[i].data));
      applyStimulus(tbl[i].we, tbl[i].addr, tbl[i].data, rd, re, lat, bAcc, rAfter);
      e = sbq.pop_front();
      testsRun++;
      if ({rd, re} !== {e.data, e.err} || lat !== WAITS) begin
        testsFailed++;
        $display("[TB] FAIL write_read[%0d]: got %h/%b lat %0d expected %h/%b lat %0d", i, rd, re, lat, e.data, e.err, WAITS);
      end
    end
  endtask

  task automatic test_boundary();
    txn_t tbl[4] = '{'{1'b1, BASE + 32'h7C, 32'hCAFEF00D},
                     '{1'b0, BASE + 32'h7C, 32'h0},
                     '{1'b1, BASE + 32'h80, 32'h11111111},
                     '{1'b0, BASE + 32'h7C, 32'h0}};
    exp_t e;
    logic [31:0] rd;
    logic re, bAcc, rAfter;
    int lat;
    foreach (tbl[i]) begin
      sbq.push_back(modelAccess(tbl[i].we, tbl[i].addr, tbl[i].data));
      applyStimulus(tbl[i].we, tbl[i].addr, tbl[i].data, rd, re, lat, bAcc, rAfter);
      e = sbq.pop_front();
      testsRun++;
      if ({rd, re} !== {e.data, e.err} || lat !== WAITS) begin
        testsFailed++;
        $display("[TB] FAIL boundary[%0d]: got %h/%b lat %0d expected %h/%b lat %0d", i, rd, re, lat, e.data, e.err, WAITS);
      end
    end
  endtask

  task automatic test_errors();
    txn_t tbl[6] = '{'{1'b0, 32'h1000FFFC, 32'h0},
                     '{1'b0, BASE + 32'h4, 32'h0},
                     '{1'b1, 32'h10010002, 32'h22222222},
                     '{1'b1, 32'h1000FFFC, 32'h33333333},
                     '{1'b0, BASE, 32'h0},
                     '{1'b0, 32'h10010006, 32'h0}};
    exp_t e;
    logic [31:0] rd;
    logic re, bAcc, rAfter;
    int lat;
    foreach (tbl[i]) begin
      sbq.push_back(modelAccess(tbl[i].we, tbl[i].addr, tbl[i].data));
      applyStimulus(tbl[i].we, tbl[i].addr, tbl[i].data, rd, re, lat, bAcc, rAfter);
      e = sbq.pop_front();
      testsRun++;
      if ({rd, re} !== {e.data, e.err} || lat !== WAITS) begin
        testsFailed++;
        $display("[TB] FAIL errors[%0d]: got %h/%b lat %0d expected %h/%b lat %0d", i, rd, re, lat, e.data, e.err, WAITS);
      end
    end
  endtask

  // Zero-wait instance with ena held high: ready every second cycle, and inputs
  // changed during the response cycle only take effect at the next acceptance.
  task automatic test_back_to_back();
    logic [4:0] expRdy = 5'b10101;
    exp_t e;
    ena0 = 1'b1; wena0 = 1'b1; addr0 = BASE + 32'h8; din0 = 32'hA5A5A5A5;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      testsRun++;
      if (rdy0 !== expRdy[k]) begin testsFailed++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", k, rdy0, expRdy[k]); end
      if (k == 0) begin
        testsRun++;
        if (err0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_write_err: got %b expected 0", err0); end
        wena0 = 1'b0; addr0 = BASE + 32'hC; din0 = 32'h0;
        sbq.push_back('{32'h0, 1'b0});
      end else if (k == 2 || k == 4) begin
        e = sbq.pop_front();
        testsRun++;
        if ({dout0, err0} !== {e.data, e.err}) begin
          testsFailed++;
          $display("[TB] FAIL b2b_read[%0d]: got %h/%b expected %h/%b", k, dout0, err0, e.data, e.err);
        end
        if (k == 2) begin
          addr0 = BASE + 32'h8;
          sbq.push_back('{32'hA5A5A5A5, 1'b0});
        end
      end
    end
    ena0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] rd;
    logic re, bAcc, rAfter;
    int lat;
    int spurious;
    ena = 1'b1; wena = 1'b1; addr = BASE + 32'h10; dataIn = 32'h12345678;
    @(posedge clk); #1;
    ena = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    testsRun++;
    if ({ready, busy} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_mid_flags: got %b expected 00", {ready, busy}); end
    spurious = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready) spurious++;
    end
    testsRun++;
    if (spurious !== 0) begin testsFailed++; $display("[TB] FAIL reset_mid_no_ready: got %0d pulses expected 0", spurious); end
    sbq.push_back(modelAccess(1'b0, BASE + 32'h10, 32'h0));
    applyStimulus(1'b0, BASE + 32'h10, 32'h0, rd, re, lat, bAcc, rAfter);
    e = sbq.pop_front();
    testsRun++;
    if ({rd, re} !== {e.data, e.err} || lat !== WAITS) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_read: got %h/%b lat %0d expected %h/%b lat %0d", rd, re, lat, e.data, e.err, WAITS);
    end
    sbq.push_back(modelAccess(1'b0, BASE + 32'h4, 32'h0));
    applyStimulus(1'b0, BASE + 32'h4, 32'h0, rd, re, lat, bAcc, rAfter);
    e = sbq.pop_front();
    testsRun++;
    if ({rd, re} !== {e.data, e.err}) begin
      testsFailed++;
      $display("[TB] FAIL reset_cleared_mem: got %h/%b expected %h/%b", rd, re, e.data, e.err);
    end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0; wena = 1'b0; addr = '0; dataIn = '0;
    ena0 = 1'b0; wena0 = 1'b0; addr0 = '0; din0 = '0;
    test_reset();
    test_read_basic();
    test_write_read();
    test_boundary();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
